hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the number of MEM_WAIT cycles before err_timeout is set.
REQ-002 SHALL have ports clk in 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst in 1: reset is synchronous and active-low.
REQ-004 SHALL have ports id_src1 in 4 and id_src2 in 4: source registers of the instruction in ID.
REQ-005 SHALL have port id_two_src in 1: ID instruction reads id_src2.
REQ-006 SHALL have ports exe_dest in 4, exe_wb_en in 1, exe_mem_r_en in 1: the ID/EX register outputs dest, wb_en, mem_r_en.
REQ-007 SHALL have ports mem_dest in 4, mem_wb_en in 1: the EX/MEM register destination and writeback enable.
REQ-008 SHALL have ports mem_req in 1 (MEM stage starts an access) and mem_ready in 1 (memory completes the access).
REQ-009 SHALL have port branch_taken in 1: EX resolves a taken branch.
REQ-010 SHALL have outputs freeze in 1 (hold PC, IF/ID and ID/EX freeze) and flush_if in 1 (clear IF/ID).
REQ-011 SHALL have outputs flush_id in 1 (bubble into the ID/EX register flush) and freeze_all in 1 (hold every pipeline register).
REQ-012 SHALL have outputs state in 2, stall_cnt in 8 and err_timeout in 1.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1 and FLUSH=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-014 SHALL define hit1 = id_src1==D and hit2 = id_two_src & (id_src2==D), where D is the stage destination under test.
REQ-015 In RUN, a mem_req with mem_ready=0 SHALL move to MEM_WAIT next edge; with mem_ready=1 the state SHALL stay RUN and no stall occurs.
REQ-016 In MEM_WAIT, freeze_all=1 and freeze=1 combinationally; mem_ready=1 SHALL return to RUN next edge, and freeze_all SHALL drop in the cycle after ready.
REQ-017 A wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; reaching MEM_TIMEOUT-1 SHALL set sticky err_timeout, and the FSM SHALL stay in MEM_WAIT.
REQ-018 In RUN with branch_taken=1, flush_if=1 and flush_id=1 in the same cycle, then FLUSH for exactly one cycle with flush_id=1, then RUN.
REQ-019 Priority SHALL be MEM_WAIT over branch over data hazard; a branch during MEM_WAIT SHALL be ignored, because EX is held and the branch re-presents after the wait.
REQ-020 A data hazard in RUN with no branch SHALL give freeze=1 and flush_id=1 combinationally in the same cycle.
REQ-021 Branch and hazard in the same cycle: flush SHALL win and freeze SHALL be 0.
REQ-022 stall_cnt SHALL increment on every cycle with freeze=1 and saturate at 255.
REQ-023 state SHALL mirror the FSM register.

Reset
REQ-024 rst=0 at an edge SHALL force state=RUN, stall_cnt=0, wait counter=0 and err_timeout=0; combinational outputs SHALL then be 0 absent hazards.
REQ-025 Reset mid-MEM_WAIT SHALL drop freeze_all in the cycle after the reset edge.

Configuration
REQ-026 Macro HAZARD_FORWARDING_EN defined: a hazard is exe_mem_r_en & exe_wb_en & (hit1|hit2 vs exe_dest), i.e. load-use only.
REQ-027 Macro HAZARD_FORWARDING_EN undefined: a hazard is (exe_wb_en & hit vs exe_dest) | (mem_wb_en & hit vs mem_dest).

Verification
REQ-028 Forwarding on: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3 -> freeze=1, flush_id=1 for that cycle, stall_cnt 0->1.
REQ-029 Forwarding off: mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> freeze=1; with id_two_src=0 -> freeze=0.
REQ-030 mem_req=1, mem_ready low 3 cycles -> state=1 for 3 cycles, freeze_all=1, then state=0 and freeze_all=0 the cycle after ready.
REQ-031 branch_taken=1 together with a load-use hazard -> flush_if=1, flush_id=1, freeze=0, then state=2 for one cycle, then 0.
REQ-032 mem_ready held 0 for 20 cycles with MEM_TIMEOUT=16 -> err_timeout=1 after the 16th cycle; rst=0 clears it and state=0.
REQ-033 300 consecutive hazard cycles -> stall_cnt=255 and holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller.
//
// Produces freeze/flush control for a five-stage pipeline. It handles three
// conditions, listed from highest to lowest priority:
//   1. Outstanding memory accesses. The controller sits in MEM_WAIT and holds
//      every pipeline register until mem_ready arrives.
//   2. Taken branches. IF/ID is cleared and a bubble goes into ID/EX for this
//      cycle and for one extra FLUSH cycle.
//   3. Read-after-write data hazards between ID and the later stages.
//      PC, IF/ID and ID/EX are frozen and a bubble goes into ID/EX.
//
// Configuration macro HAZARD_FORWARDING_EN:
//   defined   - forwarding paths exist, so only a load-use hazard against EX
//               stalls the pipeline.
//   undefined - no forwarding, so any pending write in EX or MEM to a source
//               register stalls the pipeline.
//
// Ports:
//   clk          single clock; all state updates on the rising edge
//   rst          synchronous, active-low reset
//   id_src1/2    source registers of the instruction in ID
//   id_two_src   the ID instruction also reads id_src2
//   exe_dest, exe_wb_en, exe_mem_r_en   ID/EX register fields
//   mem_dest, mem_wb_en                 EX/MEM register fields
//   mem_req      the MEM stage starts an access this cycle
//   mem_ready    memory completes the access this cycle
//   branch_taken EX resolves a taken branch
//   freeze       hold PC, IF/ID and ID/EX (combinational)
//   flush_if     clear IF/ID (combinational)
//   flush_id     bubble into ID/EX (combinational)
//   freeze_all   hold every pipeline register (combinational)
//   state        FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH
//   stall_cnt    saturating count of cycles with freeze=1
//   err_timeout  sticky flag; set when a memory wait reaches MEM_TIMEOUT cycles
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       freeze,
  output logic       flush_if,
  output logic       flush_id,
  output logic       freeze_all,
  output logic [1:0] state,
  output logic [7:0] stall_cnt,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  // The wait counter only has to reach MEM_TIMEOUT-1. It then parks there,
  // so it never wraps and re-arms.
  localparam int              WCW       = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0]  WAIT_ONE  = WCW'(1);

  state_t         state_r;
  logic [WCW-1:0] wait_cnt_r;
  logic           err_r;
  logic [7:0]     stall_cnt_r;

  logic hazard_s;
  logic freeze_s;
  logic flush_if_s;
  logic flush_id_s;
  logic freeze_all_s;

  // True when the ID instruction reads register d.
  function automatic logic dest_hit(input logic [3:0] d, input logic [3:0] s1,
                                    input logic [3:0] s2, input logic two);
    return (s1 == d) | (two & (s2 == d));
  endfunction

`ifdef HAZARD_FORWARDING_EN
  // MEM-stage fields are not needed when forwarding covers them.
  logic unused_s;
  assign unused_s = ^{mem_dest, mem_wb_en};

  // With forwarding, only a load whose data is not yet available stalls.
  always_comb begin
    hazard_s = exe_mem_r_en & exe_wb_en &
               dest_hit(exe_dest, id_src1, id_src2, id_two_src);
  end
`else
  // Without forwarding, a load and an ALU op stall alike.
  logic unused_s;
  assign unused_s = exe_mem_r_en;

  // Without forwarding, any pending write in EX or MEM to a source stalls.
  always_comb begin
    hazard_s = (exe_wb_en & dest_hit(exe_dest, id_src1, id_src2, id_two_src)) |
               (mem_wb_en & dest_hit(mem_dest, id_src1, id_src2, id_two_src));
  end
`endif

  // Pipeline control decode. The memory wait dominates; then a branch flush
  // beats a data-hazard freeze, because the stalled instruction is squashed.
  always_comb begin
    freeze_s     = 1'b0;
    flush_if_s   = 1'b0;
    flush_id_s   = 1'b0;
    freeze_all_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (branch_taken) begin
          flush_if_s = 1'b1;
          flush_id_s = 1'b1;
        end else if (hazard_s) begin
          freeze_s   = 1'b1;
          flush_id_s = 1'b1;
        end else begin
          freeze_s   = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        freeze_s     = 1'b1;
        freeze_all_s = 1'b1;
      end
      ST_FLUSH: begin
        flush_id_s   = 1'b1;
      end
      default: begin
        freeze_s     = 1'b0;
      end
    endcase
  end

  // Controller FSM, together with the memory-wait timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= '0;
          end else if (branch_taken) begin
            state_r    <= ST_FLUSH;
          end else begin
            state_r    <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          // A branch seen here is ignored: EX is held and re-presents it later.
          if (wait_cnt_r == WAIT_LAST) begin
            err_r      <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
          if (mem_ready) begin
            state_r    <= ST_RUN;
          end else begin
            state_r    <= ST_MEM_WAIT;
          end
        end
        ST_FLUSH: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of frozen cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 8'd0;
    end else if (freeze_s && (stall_cnt_r != 8'hFF)) begin
      stall_cnt_r <= stall_cnt_r + 8'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign freeze      = freeze_s;
  assign flush_if    = flush_if_s;
  assign flush_id    = flush_id_s;
  assign freeze_all  = freeze_all_s;
  assign state       = state_r;
  assign stall_cnt   = stall_cnt_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a vector table, directed multi-cycle
// sequences, and randomized traffic compared against a behavioural model.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_req, mem_ready, branch_taken;
  logic       freeze, flush_if, flush_id, freeze_all, err_timeout;
  logic [1:0] state;
  logic [7:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .freeze(freeze), .flush_if(flush_if), .flush_id(flush_id),
    .freeze_all(freeze_all), .state(state), .stall_cnt(stall_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2;
    logic       two;
    logic [3:0] exd;
    logic       exwb, exr;
    logic [3:0] md;
    logic       mwb, br;
    logic       frz, fi, fid;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mkv(input int s1, input int s2, input bit two,
                               input int exd, input bit exwb, input bit exr,
                               input int md, input bit mwb, input bit br,
                               input bit frz, input bit fi, input bit fid);
    vec_t v;
    v.s1 = 4'(s1); v.s2 = 4'(s2); v.two = two;
    v.exd = 4'(exd); v.exwb = exwb; v.exr = exr;
    v.md = 4'(md); v.mwb = mwb; v.br = br;
    v.frz = frz; v.fi = fi; v.fid = fid;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b1;
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    idle();
    id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    exe_dest = v.exd; exe_wb_en = v.exwb; exe_mem_r_en = v.exr;
    mem_dest = v.md; mem_wb_en = v.mwb; branch_taken = v.br;
  endtask

  // Load-use hazard on register 3: a hazard with or without forwarding.
  task automatic load_use();
    idle();
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode;     // 0 running, 1 waiting on memory, 2 flushing
  int m_waited;   // completed cycles of the current memory wait
  bit m_err;
  int m_stalls;
  bit e_frz, e_fi, e_fid, e_fa;

  function automatic bit m_hazard();
    int reads[$];
    int writers[$];
    reads.push_back(int'(id_src1));
    if (id_two_src) reads.push_back(int'(id_src2));
    if (FWD) begin
      if (exe_wb_en && exe_mem_r_en) writers.push_back(int'(exe_dest));
    end else begin
      if (exe_wb_en) writers.push_back(int'(exe_dest));
      if (mem_wb_en) writers.push_back(int'(mem_dest));
    end
    foreach (reads[i])
      foreach (writers[j])
        if (reads[i] == writers[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_eval();
    bit hz;
    hz    = m_hazard();
    e_fa  = (m_mode == 1);
    e_fi  = (m_mode == 0) && branch_taken;
    e_frz = (m_mode == 1) || ((m_mode == 0) && !branch_taken && hz);
    e_fid = (m_mode == 2) || ((m_mode == 0) && (branch_taken || hz));
  endtask

  task automatic m_step();
    if (!rst) begin
      m_mode = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0;
    end else begin
      if (e_frz && m_stalls < 255) m_stalls++;
      if (m_mode == 0) begin
        if (mem_req && !mem_ready) begin
          m_mode = 1; m_waited = 0;
        end else if (branch_taken) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        m_waited++;
        if (m_waited >= TO) m_err = 1'b1;
        if (mem_ready) m_mode = 0;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Columns: s1 s2 two exd exwb exr md mwb br | frz fi fid
    vt[0] = mkv(3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1] = mkv(3, 0, 0, 3, 1, 0, 0, 0, 0, !FWD, 0, !FWD);
    vt[2] = mkv(3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 1);
    vt[3] = mkv(1, 5, 1, 0, 0, 0, 5, 1, 0, !FWD, 0, !FWD);
    vt[4] = mkv(1, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    vt[5] = mkv(1, 2, 1, 9, 0, 0, 9, 0, 1, 0, 1, 1);
    vt[6] = mkv(3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 1, 1);
    vt[7] = mkv(2, 7, 1, 7, 1, 1, 0, 0, 0, 1, 0, 1);
    vt[8] = mkv(2, 7, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[9] = mkv(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1);

    // Reset state with idle inputs.
    do_reset();
    #2;
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_flush_if", flush_if, 0);
    chk("rst_flush_id", flush_id, 0);
    chk("rst_freeze_all", freeze_all, 0);

    // Combinational decode table, one vector per reset cycle.
    for (int i = 0; i < 10; i++) begin
      apply_vec(vt[i]);
      #2;
      chk($sformatf("vec%0d_freeze", i), freeze, vt[i].frz);
      chk($sformatf("vec%0d_flush_if", i), flush_if, vt[i].fi);
      chk($sformatf("vec%0d_flush_id", i), flush_id, vt[i].fid);
      chk($sformatf("vec%0d_freeze_all", i), freeze_all, 0);
      do_reset();
    end

    // A single load-use cycle adds one stall.
    #2;
    chk("lu_stall_before", stall_cnt, 0);
    load_use();
    #2;
    chk("lu_freeze", freeze, 1);
    chk("lu_flush_id", flush_id, 1);
    tick();
    idle();
    #2;
    chk("lu_stall_after", stall_cnt, 1);
    chk("lu_freeze_after", freeze, 0);

    // A memory request with immediate ready causes no wait.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b1;
    #2;
    chk("memrdy_freeze", freeze, 0);
    tick();
    #2;
    chk("memrdy_state", state, 0);

    // Memory wait: ready low for 3 cycles, then high.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    #2;
    chk("mw_req_state", state, 0);
    chk("mw_req_fa", freeze_all, 0);
    tick();
    mem_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      branch_taken = (i == 1);   // a branch during the wait is ignored
      #2;
      chk("mw_state", state, 1);
      chk("mw_fa", freeze_all, 1);
      chk("mw_freeze", freeze, 1);
      chk("mw_flush_if", flush_if, 0);
      tick();
    end
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk("mw_ready_state", state, 1);
    chk("mw_ready_fa", freeze_all, 1);
    tick();
    #2;
    chk("mw_after_state", state, 0);
    chk("mw_after_fa", freeze_all, 0);

    // A branch with a simultaneous load-use hazard: the flush wins.
    do_reset();
    load_use();
    branch_taken = 1'b1;
    #2;
    chk("br_flush_if", flush_if, 1);
    chk("br_flush_id", flush_id, 1);
    chk("br_freeze", freeze, 0);
    tick();
    idle();
    #2;
    chk("br_flush_state", state, 2);
    chk("br_flush_flush_id", flush_id, 1);
    chk("br_flush_flush_if", flush_if, 0);
    tick();
    #2;
    chk("br_back_state", state, 0);
    chk("br_back_flush_id", flush_id, 0);

    // Timeout: ready stays low for 20 wait cycles.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    mem_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #2;
      chk($sformatf("to_err_c%0d", k), err_timeout, (k > TO) ? 1 : 0);
      chk($sformatf("to_state_c%0d", k), state, 1);
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    #2;
    chk("to_rst_err", err_timeout, 0);
    chk("to_rst_state", state, 0);

    // Reset in the middle of a memory wait.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    mem_req = 1'b0;
    tick();
    #2;
    chk("mwrst_fa_before", freeze_all, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    chk("mwrst_fa_after", freeze_all, 0);
    chk("mwrst_state", state, 0);

    // Stall counter saturation.
    do_reset();
    load_use();
    for (int i = 0; i < 300; i++) tick();
    #2;
    chk("sat_stall", stall_cnt, 255);
    tick();
    #2;
    chk("sat_hold", stall_cnt, 255);

    // Randomized traffic against the model. The second half makes memory
    // slow so that timeouts occur.
    do_reset();
    m_mode = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0;
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 99) != 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom_range(0, 1));
      exe_dest     = 4'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest     = 4'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 5) == 0);
      mem_ready    = (n < 700) ? ($urandom_range(0, 3) != 0)
                               : ($urandom_range(0, 24) == 0);
      m_eval();
      #2;
      chk("rnd_freeze", freeze, e_frz);
      chk("rnd_flush_if", flush_if, e_fi);
      chk("rnd_flush_id", flush_id, e_fid);
      chk("rnd_freeze_all", freeze_all, e_fa);
      chk("rnd_state", state, m_mode);
      chk("rnd_stall", stall_cnt, m_stalls);
      chk("rnd_err", err_timeout, m_err);
      m_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
